// File: rtl/uart_pkg.sv
// Shared UART types and line-level constants for the TX frame controller and future RX path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Parity bit generator shared by the UART TX controller and the RX parity checker.
// Purely combinational, zero latency; no flow control.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity makes the total count of ones even, so the bit is the plain XOR.
  always_comb begin
    par_bit = ^data;
    if (par_typ == PAR_ODD) begin
      par_bit = ~^data;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: start, DATA_WIDTH bits LSB-first from the serializer, optional parity, stop.
// Start bit on TX_OUT one edge after acceptance; requests are dropped unless in IDLE or STOP (no queueing).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_done,
  input  logic                  ser_data,
  output logic [DATA_WIDTH-1:0] S_DATA,
  output logic                  ser_en,
  output logic                  TX_OUT,
  output logic                  busy
);

  tx_state_t state;
  tx_state_t state_nxt;
  logic      par_en_q;
  logic      par_typ_q;
  logic      par_bit;
  logic      accept;
  logic      tx_nxt;

  // STOP also accepts so a back-to-back frame starts with no idle gap on the line.
  assign accept = Data_Valid && ((state == IDLE) || (state == STOP));

  parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity_calc (
    .data    (S_DATA),
    .par_typ (par_typ_q),
    .par_bit (par_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = DATA;
      DATA:    if (ser_done) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b1;
    ser_en = 1'b0;
    tx_nxt = IDLE_LINE;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        tx_nxt = IDLE_LINE;
      end
      START:  tx_nxt = START_BIT;
      DATA: begin
        ser_en = 1'b1;
        tx_nxt = ser_data;
      end
      PARITY: tx_nxt = par_bit;
      STOP:   tx_nxt = STOP_BIT;
      default: begin
        busy   = 1'b0;
        tx_nxt = IDLE_LINE;
      end
    endcase
  end

  // Payload and parity config are frozen at acceptance for the whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      S_DATA    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (accept) begin
      S_DATA    <= P_DATA;
      par_en_q  <= PAR_EN;
      par_typ_q <= PAR_TYP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      TX_OUT <= IDLE_LINE;
    end else begin
      TX_OUT <= tx_nxt;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame controller for the UART transmitter, sitting directly upstream of the serializer. It accepts a parallel byte with a one-cycle valid strobe and latches it. It drives the serializer through S_DATA/ser_en and consumes ser_data/ser_done. It builds the line frame: start bit, 8 data bits LSB-first, optional parity, stop bit. One clk cycle equals one bit period, since clk is the baud-rate clock.

Parameters:
DATA_WIDTH, 8, payload width; must match the serializer width.

Ports:
clk        input   1           bit-rate clock; all logic on rising edge
rst        input   1           synchronous, active-high reset
P_DATA     input   DATA_WIDTH  byte to transmit; sampled only when accepted
Data_Valid input   1           request strobe; accepted only in IDLE or STOP
PAR_EN     input   1           1 = insert parity bit; sampled at acceptance
PAR_TYP    input   1           0 = even, 1 = odd; sampled at acceptance
ser_done   input   1           serializer flag: high in the cycle it presents the last data bit
ser_data   input   1           current serial bit from the serializer
S_DATA     output  DATA_WIDTH  latched byte held stable to the serializer for the whole frame
ser_en     output  1           serializer shift enable; high exactly in DATA state
TX_OUT     output  1           registered serial line; idles high
busy       output  1           high from acceptance until the stop bit completes

Behaviour:
- Reset (rst sampled high at an edge): state IDLE; TX_OUT=1, busy=0, ser_en=0, S_DATA=0; parity config cleared. Reset mid-frame aborts the frame; the line is high from the next edge on.
- Serializer contract: while ser_en=1, ser_data carries bit i in the i-th ser_en cycle (bit0 first). ser_done is high with bit DATA_WIDTH-1.
- FSM states and transitions:
  - IDLE: Data_Valid=1 -> START. S_DATA<=P_DATA; par_en_q<=PAR_EN; par_typ_q<=PAR_TYP.
  - START: unconditional -> DATA.
  - DATA: ser_done=1 -> PARITY if par_en_q, else STOP. Otherwise remain in DATA.
  - PARITY: -> STOP.
  - STOP: Data_Valid=1 -> START, with the same latching as IDLE (back-to-back frame, no idle gap). Otherwise -> IDLE.
- Output mux, registered into TX_OUT (state of cycle n appears on TX_OUT after edge n+1):
  - IDLE=1, START=0, DATA=ser_data, PARITY=par_bit, STOP=1.
- Parity:
  - par_bit = ^S_DATA for even; ~^S_DATA for odd.
  - Computed from latched S_DATA only; P_DATA changes after acceptance have no effect.
- Timing, taking acceptance at edge k:
  - busy=1 after edge k.
  - Start bit on TX_OUT after edge k+1.
  - Data bit i after edge k+2+i.
  - Parity after edge k+10 (if enabled).
  - Stop bit after edge k+11, or k+10 without parity.
  - Frame is 11 bits with parity, 10 without.
- busy: Moore output, 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Data_Valid handling:
  - Ignored in START/DATA/PARITY (no queueing, no S_DATA change).
  - Data_Valid and rst in the same cycle: reset wins.
- ser_en:
  - Moore output, high only in DATA.
  - If ser_done never arrives, FSM stays in DATA and ser_en stays high. This is a serializer fault, not handled here.
- Config changes (PAR_EN/PAR_TYP) mid-frame do not affect the current frame.

Decomposition:
- Package uart_pkg:
  - State encoding: IDLE, START, DATA, PARITY, STOP (3-bit).
  - Constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LINE=1'b1.
  - PAR_EVEN=1'b0, PAR_ODD=1'b1.
- Sub-module parity_calc: combinational, inputs data[DATA_WIDTH-1:0] and par_typ; output par_bit. Shared with the future RX parity checker.
- FSM, latch and output mux stay in uart_tx_ctrl.

Test Plan:
- Reset then idle 5 cycles -> TX_OUT=1, busy=0, ser_en=0 throughout.
- P_DATA=8'h8F, PAR_EN=1, PAR_TYP=0, Data_Valid 1 cycle, with a behavioural serializer -> TX_OUT sequence 0,1,1,1,1,0,0,0,1,1,1 (even parity of 5 ones =1). busy high for 11 cycles; ser_en high exactly 8 cycles.
- P_DATA=8'h9E, PAR_EN=1, PAR_TYP=1 -> data bits 0,1,1,1,1,0,0,1; parity bit 0 (5 ones); stop 1.
- P_DATA=8'h9E, PAR_EN=0 -> 10-bit frame; stop bit directly after bit7; busy high 10 cycles.
- Back-to-back: second Data_Valid (8'hA5) during STOP -> start bit immediately follows stop, no idle cycle. Data_Valid pulsed during DATA -> ignored; S_DATA stays 8'h8F.
- rst asserted in the 4th DATA cycle -> next edge TX_OUT=1, busy=0, ser_en=0. A new request 2 cycles later produces a clean full frame.
